// File: rtl/fft16_seq.sv
// Control sequencer for one 16-point radix-2 FFT: loads 16 samples, steps four
// butterfly stages with a registered capture strobe, then streams 16 result bins.
module fft16_seq #(
    parameter int unsigned STAGE_CYC = 2,
    parameter bit          BITREV    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       load_en_o,
    output logic [3:0] load_idx_o,
    output logic [1:0] stage_o,
    output logic       src_sel_o,
    output logic       ram_we_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [3:0] out_idx_o,
    output logic       out_last_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_STAGE = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [3:0] CYC_LAST = 4'(STAGE_CYC);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] stg_q, stg_d;
    logic [3:0] cyc_q, cyc_d;
    logic       ram_we_q, ram_we_d;
    logic       done_q, done_d;
    logic       ready_q;

    logic       loading;
    logic       draining;
    logic       accept;
    logic       beat;
    logic [3:0] cnt_rev;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rev
            assign cnt_rev[gi] = cnt_q[3-gi];
        end
    endgenerate

    assign loading  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign draining = (state_q == S_DRAIN);
    // ready_q keeps in_ready low until the first clock edge after reset release
    assign accept   = in_valid_i && ready_q && loading;
    assign beat     = draining && out_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        cyc_d   = cyc_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_LOAD;
                    if (cnt_q == 4'd15) begin
                        state_d = S_STAGE;
                        stg_d   = 2'd0;
                        cyc_d   = 4'd0;
                    end
                end
            end
            S_STAGE: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = 4'd0;
                    stg_d = stg_q + 2'd1;
                    if (stg_q == 2'd3) begin
                        state_d = S_DRAIN;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (beat) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Strobe is decoded from next-state so it leaves a flop glitch-free
        ram_we_d = (state_d == S_STAGE) && (cyc_d == CYC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            stg_q    <= 2'd0;
            cyc_q    <= 4'd0;
            ram_we_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stg_q    <= stg_d;
            cyc_q    <= cyc_d;
            ram_we_q <= ram_we_d;
            done_q   <= done_d;
            ready_q  <= 1'b1;
        end
    end

    assign in_ready_o  = ready_q && loading;
    assign load_en_o   = accept;
    assign load_idx_o  = loading ? cnt_q : 4'd0;
    assign stage_o     = (state_q == S_STAGE) ? stg_q : 2'd0;
    assign src_sel_o   = (state_q == S_STAGE) && (stg_q != 2'd0);
    assign ram_we_o    = ram_we_q;
    assign out_valid_o = draining;
    assign out_idx_o   = draining ? (BITREV ? cnt_rev : cnt_q) : 4'd0;
    assign out_last_o  = draining && (cnt_q == 4'd15);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_fft16_seq.sv
// Bench for fft16_seq: two instances (default params, and STAGE_CYC=1/BITREV=0)
// driven in lockstep; per-instance monitors score timing and output order.
module tb_fft16_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_drv;
    logic       en_b;
    logic       out_ready;
    logic [1:0] in_valid;
    logic [1:0] in_ready, load_en, src_sel, ram_we, out_valid, out_last, busy, done;
    logic [3:0] load_idx [2];
    logic [1:0] stage    [2];
    logic [3:0] out_idx  [2];

    int errors = 0;
    int checks = 0;

    localparam int BR [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clk = ~clk;

    assign in_valid = {in_valid_drv & en_b, in_valid_drv};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int SCV  = (gi == 0) ? 2 : 1;
            localparam int LAST = 4 * (SCV + 1);

            int exp_q [$];
            int k        = 0;
            int la_exp   = 0;
            int e        = 0;
            bit done_exp = 1'b0;
            bit start    = 1'b0;
            bit we_e     = 1'b0;

            fft16_seq #(.STAGE_CYC(SCV), .BITREV(gi == 0)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .in_valid_i (in_valid[gi]),
                .in_ready_o (in_ready[gi]),
                .load_en_o  (load_en[gi]),
                .load_idx_o (load_idx[gi]),
                .stage_o    (stage[gi]),
                .src_sel_o  (src_sel[gi]),
                .ram_we_o   (ram_we[gi]),
                .out_valid_o(out_valid[gi]),
                .out_ready_i(out_ready),
                .out_idx_o  (out_idx[gi]),
                .out_last_o (out_last[gi]),
                .busy_o     (busy[gi]),
                .done_o     (done[gi])
            );

            initial forever begin
                @(negedge clk);
                if (!rst_n) begin
                    k        = 0;
                    la_exp   = 0;
                    done_exp = 1'b0;
                end else begin
                    start = 1'b0;
                    chk($sformatf("u%0d load_en", gi), load_en[gi], in_valid[gi] & in_ready[gi]);
                    if (load_en[gi]) begin
                        chk($sformatf("u%0d load_idx", gi), load_idx[gi], la_exp);
                        if (la_exp == 15) start = 1'b1;
                        la_exp = (la_exp + 1) % 16;
                    end
                    we_e = (k >= 1) && (k <= LAST) && ((k % (SCV + 1)) == 0);
                    chk($sformatf("u%0d ram_we k=%0d", gi, k), ram_we[gi], we_e);
                    if (we_e) begin
                        chk($sformatf("u%0d stage k=%0d", gi, k), stage[gi], k / (SCV + 1) - 1);
                        chk($sformatf("u%0d src_sel k=%0d", gi, k), src_sel[gi], (k / (SCV + 1)) > 1);
                    end
                    if (k >= 1 && k <= LAST)
                        chk($sformatf("u%0d in_ready_stage", gi), in_ready[gi], 0);
                    if (k == LAST + 1)
                        chk($sformatf("u%0d drain_entry", gi), out_valid[gi], 1);
                    if (done[gi])
                        chk($sformatf("u%0d accept_in_done", gi), load_en[gi], in_valid[gi]);
                    chk($sformatf("u%0d done", gi), done[gi], done_exp);
                    done_exp = 1'b0;
                    if (out_valid[gi] && out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL u%0d unexpected_beat: got out_idx %0d expected no beat", gi, out_idx[gi]);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("u%0d out_idx", gi), out_idx[gi], e & 15);
                            chk($sformatf("u%0d out_last", gi), out_last[gi], e >> 4);
                            done_exp = (e >> 4) != 0;
                        end
                    end
                    if (k != 0) k = (k == LAST + 1) ? 0 : k + 1;
                    if (start) k = 1;
                end
            end
        end
    endgenerate

    task automatic push_tf(input bit both);
        for (int i = 0; i < 16; i++) begin
            g_dut[0].exp_q.push_back(BR[i] | ((i == 15) ? 16 : 0));
            if (both) g_dut[1].exp_q.push_back(i | ((i == 15) ? 16 : 0));
        end
    endtask

    task automatic drive(input int n, input bit toggle, output int cyc);
        int acc = 0;
        bit ph  = 1'b1;
        cyc = 0;
        while (acc < n && cyc < 400) begin
            @(posedge clk);
            #1;
            in_valid_drv = toggle ? ph : 1'b1;
            ph = !ph;
            @(negedge clk);
            cyc++;
            if (in_valid[0] && in_ready[0]) acc++;
        end
        @(posedge clk);
        #1;
        in_valid_drv = 1'b0;
        chk("accept_count", acc, n);
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((g_dut[0].exp_q.size() != 0 || g_dut[1].exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (g_dut[0].exp_q.size() != 0 || g_dut[1].exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d bins pending expected 0",
                     g_dut[0].exp_q.size(), g_dut[1].exp_q.size());
            g_dut[0].exp_q.delete();
            g_dut[1].exp_q.delete();
        end
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int cyc;
        int n;
        rst_n        = 1'b0;
        in_valid_drv = 1'b0;
        en_b         = 1'b1;
        out_ready    = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst ram_we", ram_we, 0);
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst done", done, 0);
        chk("rst load_en", load_en, 0);
        chk("rst src_sel", src_sel, 0);
        chk("rst stage", stage[0], 0);
        chk("rst out_idx", out_idx[0], 0);
        chk("rst load_idx", load_idx[0], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", in_ready, 3);

        // back-to-back load, free-running drain
        push_tf(1'b1);
        drive(16, 1'b0, cyc);
        chk("b2b_load_cycles", cyc, 16);
        wait_empty();

        // in_valid every other cycle
        push_tf(1'b1);
        drive(16, 1'b1, cyc);
        chk("toggle_load_cycles", cyc, 31);
        wait_empty();

        // out_ready stall at cnt=7
        push_tf(1'b1);
        drive(16, 1'b0, cyc);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(out_valid[0] && out_idx[0] == 4'd14) && n < 200);
        chk("stall_reached", out_idx[0], 14);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall out_idx", out_idx[0], 14);
            chk("stall out_valid", out_valid[0], 1);
            chk("stall out_last", out_last[0], 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_empty();

        // reset during stage 2
        drive(16, 1'b0, cyc);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (stage[0] != 2'd2 && n < 100);
        chk("stage2_reached", stage[0], 2);
        rst_n = 1'b0;
        #1;
        chk("midrst ram_we now", ram_we, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst ram_we", ram_we, 0);
            chk("midrst busy", busy, 0);
            chk("midrst out_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst in_ready", in_ready, 3);
        chk("post_rst busy", busy, 0);
        push_tf(1'b1);
        drive(16, 1'b0, cyc);
        wait_empty();

        // in_valid held high: second transform starts in the done cycle
        en_b = 1'b0;
        push_tf(1'b0);
        push_tf(1'b0);
        drive(32, 1'b0, cyc);
        wait_empty();
        en_b = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft16_seq.md
# fft16_seq

Sequencer for the 16-point FFT datapath. It accepts 16 complex samples over a valid/ready stream and steers them into the input buffer. It then steps the four radix-2 butterfly stages, pulsing the write strobe of the 16-word stage register once per stage, and streams the 16 result bins out in bit-reversed or natural order. It owns all control for one transform; it does not touch data.

## Interface
- STAGE_CYC, 2: settle cycles allowed for butterfly logic before each capture strobe; legal 1..15.
- BITREV, 1: 1 = out_idx emitted bit-reversed; 0 = natural order.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream sample present.
- in_ready  out  1  sequencer can accept a sample.
- load_en  out  1  write current sample into input buffer at load_idx.
- load_idx  out  4  input buffer write address.
- stage  out  2  active butterfly stage (twiddle/pairing select).
- src_sel  out  1  0 = butterflies read input buffer, 1 = read stage register.
- ram_we  out  1  capture strobe to stage register (data latched on its rising edge).
- out_valid  out  1  result bin available.
- out_ready  in  1  downstream accepts bin.
- out_idx  out  4  stage register word to present on output.
- out_last  out  1  final bin of transform.
- busy  out  1  high in LOAD, STAGE and DRAIN.
- done  out  1  one-cycle pulse after final output beat.

## Operation
- States: IDLE, LOAD, STAGE, DRAIN.
- Counters:
  - cnt[3:0]: load and drain beats.
  - stg[1:0]: stage number.
  - cyc[3:0]: cycles within a stage.
- IDLE and LOAD:
  - in_ready = 1.
  - Accept = in_valid & in_ready. load_en = accept (combinational). load_idx = cnt.
  - Each accept increments cnt.
  - First accept in IDLE moves to LOAD. Accept at cnt=15 moves to STAGE with stg=0, cyc=0, cnt=0.
- STAGE:
  - in_ready = 0. stage = stg. src_sel = (stg != 0).
  - cyc counts 0..STAGE_CYC.
  - ram_we is high exactly in the cycle where cyc = STAGE_CYC. At that point cyc clears and stg increments.
  - ram_we with stg=3 moves to DRAIN.
- DRAIN:
  - out_valid = 1. out_idx = bitrev(cnt) if BITREV, else cnt.
  - out_last = (cnt = 15).
  - Beat = out_valid & out_ready increments cnt. Beat with cnt=15 moves to IDLE and sets done for the next cycle.
- Outside STAGE: stage = 0, src_sel = 0, ram_we = 0.
- Outside DRAIN: out_valid = 0, out_last = 0, out_idx = 0.
- in_valid outside IDLE/LOAD is ignored; no sample is lost because in_ready = 0.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE; cnt, stg and cyc = 0.
  - ram_we, done, out_valid, out_last, load_en and busy = 0. stage = 0, src_sel = 0, load_idx = 0, out_idx = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 from the first clk after release.
- ram_we comes directly from a flop; it must never glitch, because the stage register is edge-triggered on it.
- Load: one sample per cycle at full rate. in_valid gaps stall cnt; nothing else changes.
- Stage phase: 4*(STAGE_CYC+1) cycles, starting the cycle after the 16th accept. With default STAGE_CYC=2 this is 12 cycles, and ram_we is high in cycles 3, 6, 9 and 12.
- DRAIN is entered the cycle after the 4th ram_we. Minimum drain is 16 cycles with out_ready held high.
- out_ready low holds out_idx, out_valid and out_last stable.
- done is high for one cycle, coincident with IDLE. A new accept is legal in that same cycle.
- busy stays high from the first accept through the last drain beat.
- Reset mid-transform abandons all progress. No ram_we pulse may be produced after rst_n falls.

## Test plan
- Reset then 16 back-to-back samples, out_ready=1:
  - load_idx runs 0..15 with load_en high for 16 cycles.
  - ram_we pulses 3 cycles apart with stage = 0, 1, 2, 3; src_sel is 0 then 1, 1, 1.
  - out_idx sequence is 0, 8, 4, 12, 2, …, 15. out_last is high on the 16th beat; done pulses once.
- in_valid toggled every other cycle: 16 accepts take 31 cycles. load_idx only advances on accepts; stage timing after that is unchanged.
- out_ready low for 5 cycles at cnt=7: out_idx holds 14 (bit-reversed 7) and out_valid stays 1. After release, 9 beats remain and complete.
- BITREV=0, STAGE_CYC=1:
  - ram_we pulses every 2 cycles, 8 cycles total.
  - out_idx is 0..15 in order.
- rst_n pulsed low during stage 2: ram_we stays 0, busy returns to 0 and the state returns to IDLE. The next 16 samples produce a complete normal transform.
- in_valid held high through STAGE/DRAIN: no load_en while in_ready = 0. A new transform starts in the done cycle.
